jogo_memoria_param: RTL and testbench
=====================================

JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameter WIDTH, 4, bit width of chaves and of each stored sequence entry; the module SHALL accept any value >= 1.
REQ-002 Parameter DEPTH, 16, sequence length; the module SHALL accept any value >= 2; AW = $clog2(DEPTH).
REQ-003 Parameter TIMEOUT_CYCLES, 5000, maximum cycles allowed per play in ESPERA; the module SHALL accept any value >= 2.
REQ-004 clock  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 iniciar  in  1  start/restart request, level-sampled.
REQ-007 chaves  in  WIDTH  player input value.
REQ-008 jogada  in  1  play strobe; only its rising edge SHALL count.
REQ-009 carrega, carga_end, carga_dado  in  1/AW/WIDTH  sequence-memory write port.
REQ-010 pronto, acertou, errou, timeout  out  1 each  game result flags.
REQ-011 db_contagem  out  AW  current index; db_memoria  out  WIDTH  mem[index]; db_chaves  out  WIDTH  registered play.
REQ-012 db_estado  out  4  state code; db_igual  out  1  registered play == mem[index], combinational.

Function
REQ-013 The FSM SHALL have states INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=4, COMPARA=5, PROXIMO=6, ACERTO=0xA, ERRO=0xE, ESGOTADO=0xD.
REQ-014 INICIAL: iniciar=1 SHALL move to PREPARACAO; otherwise the FSM SHALL stay in INICIAL.
REQ-015 PREPARACAO SHALL zero the index, the play register and the timeout counter, then move to ESPERA.
REQ-016 ESPERA: a jogada rising edge SHALL move to REGISTRA; iniciar SHALL be ignored.
REQ-017 REGISTRA SHALL load chaves into the play register, then move to COMPARA.
REQ-018 COMPARA: a mismatch SHALL move to ERRO; a match at index DEPTH-1 SHALL move to ACERTO; any other match SHALL move to PROXIMO.
REQ-019 PROXIMO SHALL increment the index and clear the timeout counter, then move to ESPERA; the index SHALL never wrap.
REQ-020 ACERTO/ERRO/ESGOTADO SHALL hold; iniciar=1 SHALL move to PREPARACAO.
REQ-021 Outputs: pronto=1 in ACERTO/ERRO/ESGOTADO; acertou=1 only in ACERTO; errou=1 only in ERRO; timeout=1 only in ESGOTADO.
REQ-022 Latency: an edge sampled in ESPERA at cycle t SHALL produce the REGISTRA/COMPARA/result state at t+1/t+2/t+3.
REQ-023 Edge detect: jogada_d is registered, edge = jogada & ~jogada_d; holding jogada high SHALL count once; an edge outside ESPERA SHALL be discarded.
REQ-024 Memory: DEPTH x WIDTH register array with asynchronous read at the index.
REQ-025 Memory write SHALL occur on carrega=1 only in INICIAL, ACERTO, ERRO or ESGOTADO; writes in other states SHALL be ignored.
REQ-026 carrega and iniciar in the same cycle: both the write and the transition SHALL take effect.

Reset
REQ-027 reset=0 at a clock edge SHALL force INICIAL, index 0, play register 0, timeout counter 0, jogada_d 0; all flags SHALL be 0; db_estado SHALL be 0.
REQ-028 Reset SHALL NOT clear the memory; reset mid-game SHALL abort with no result flag.

Configuration
REQ-029 Macro JOGO_TIMEOUT_EN defined: the timeout counter SHALL count ESPERA cycles, and reaching TIMEOUT_CYCLES-1 without an edge SHALL move to ESGOTADO; an edge on that same cycle SHALL win.
REQ-030 Macro undefined: there SHALL be no counter hardware, timeout SHALL be tied 0, ESGOTADO SHALL be unreachable, and ESPERA SHALL wait indefinitely.

Structure
REQ-031 Package jogo_memoria_pkg SHALL hold the state encodings and the 4-bit state width constant.
REQ-032 The FSM SHALL be one sub-module, jogo_memoria_uc; the datapath (memory, index, play register, comparator, edge detect, timeout counter) SHALL be in the top.

Verification (WIDTH=4, DEPTH=4, TIMEOUT_CYCLES=8, memory loaded 1,2,4,8)
REQ-033 Plays 1,2,4,8 -> acertou=1, pronto=1, db_estado=0xA exactly 3 cycles after the 4th edge.
REQ-034 Plays 1,4 -> errou=1, db_contagem=1, db_chaves=4, db_igual=0.
REQ-035 With JOGO_TIMEOUT_EN: no jogada after iniciar -> timeout=1 after 8 ESPERA cycles; without the macro: still in ESPERA after 100 cycles with timeout=0.
REQ-036 jogada held high for 5 cycles -> index advances by exactly 1; carrega pulse during ESPERA -> memory unchanged.
REQ-037 reset=0 at index 2 -> INICIAL and all flags 0 next cycle; iniciar then plays 1,2,4,8 -> acertou=1 (memory retained).
REQ-038 After ERRO: carrega writes 9 at address 0 with iniciar in the same cycle; plays 9,2,4,8 -> acertou=1.

Source files
------------

// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory game: FSM state encodings and state-code width.
package jogo_memoria_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h4,
    COMPARA    = 4'h5,
    PROXIMO    = 4'h6,
    ACERTO     = 4'hA,
    ERRO       = 4'hE,
    ESGOTADO   = 4'hD
  } estado_t;

endpackage

// File: rtl/jogo_memoria_uc.sv
// Control unit of the memory game: Moore FSM sequencing prepare/wait/register/compare.
// Macro JOGO_TIMEOUT_EN enables the ESGOTADO timeout flag.
module jogo_memoria_uc
  import jogo_memoria_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                borda,
  input  logic                igual,
  input  logic                fim,
  input  logic                esgotou,
  output logic                zera,
  output logic                registra,
  output logic                conta,
  output logic                pode_carregar,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  estado_t estado;
  estado_t proximo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo       = estado;
    zera          = 1'b0;
    registra      = 1'b0;
    conta         = 1'b0;
    pode_carregar = 1'b0;
    pronto        = 1'b0;
    acertou       = 1'b0;
    errou         = 1'b0;
    timeout       = 1'b0;
    case (estado)
      INICIAL: begin
        pode_carregar = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
      PREPARACAO: begin
        zera    = 1'b1;
        proximo = ESPERA;
      end
      // A play edge takes priority over an expiring timeout on the same cycle.
      ESPERA: begin
        if (borda) begin
          proximo = REGISTRA;
        end else if (esgotou) begin
          proximo = ESGOTADO;
        end
      end
      REGISTRA: begin
        registra = 1'b1;
        proximo  = COMPARA;
      end
      COMPARA: begin
        if (!igual) begin
          proximo = ERRO;
        end else if (fim) begin
          proximo = ACERTO;
        end else begin
          proximo = PROXIMO;
        end
      end
      PROXIMO: begin
        conta   = 1'b1;
        proximo = ESPERA;
      end
      ACERTO: begin
        pode_carregar = 1'b1;
        pronto        = 1'b1;
        acertou       = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
      ERRO: begin
        pode_carregar = 1'b1;
        pronto        = 1'b1;
        errou         = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
      ESGOTADO: begin
        pode_carregar = 1'b1;
        pronto        = 1'b1;
`ifdef JOGO_TIMEOUT_EN
        timeout       = 1'b1;
`endif
        if (iniciar) proximo = PREPARACAO;
      end
      default: proximo = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory game top: sequence memory, index, play register, edge detect and optional
// per-play timeout counter (enabled by macro JOGO_TIMEOUT_EN); control in jogo_memoria_uc.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  localparam int AW            = $clog2(DEPTH)
)(
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [WIDTH-1:0]    chaves,
  input  logic                jogada,
  input  logic                carrega,
  input  logic [AW-1:0]       carga_end,
  input  logic [WIDTH-1:0]    carga_dado,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [AW-1:0]       db_contagem,
  output logic [WIDTH-1:0]    db_memoria,
  output logic [WIDTH-1:0]    db_chaves,
  output logic [ESTADO_W-1:0] db_estado,
  output logic                db_igual
);

  localparam logic [AW-1:0] ULTIMO  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    indice;
  logic [WIDTH-1:0] jogada_reg;
  logic             jogada_d;
  logic             borda;
  logic             igual;
  logic             fim;
  logic             esgotou;
  logic             zera;
  logic             registra;
  logic             conta;
  logic             pode_carregar;

  assign borda = jogada & ~jogada_d;
  assign igual = (jogada_reg == mem[indice]);
  assign fim   = (indice == ULTIMO);

  always_ff @(posedge clock) begin
    if (!reset) begin
      indice     <= '0;
      jogada_reg <= '0;
      jogada_d   <= 1'b0;
    end else begin
      jogada_d <= jogada;
      // The index saturates at the last entry instead of wrapping.
      if (zera) begin
        indice <= '0;
      end else if (conta && !fim) begin
        indice <= indice + 1'b1;
      end
      if (zera) begin
        jogada_reg <= '0;
      end else if (registra) begin
        jogada_reg <= chaves;
      end
    end
  end

  // Sequence memory survives reset; writes only while the game is idle or finished.
  always_ff @(posedge clock) begin
    if (carrega && pode_carregar && ({1'b0, carga_end} < DEPTH_L)) begin
      mem[carga_end] <= carga_dado;
    end
  end

`ifdef JOGO_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tempo;
  logic          em_espera;

  assign em_espera = (db_estado == ESPERA);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tempo <= '0;
    end else if (zera || conta) begin
      tempo <= '0;
    end else if (em_espera) begin
      tempo <= tempo + 1'b1;
    end
  end

  assign esgotou = em_espera && (tempo == LIMITE);
`else
  assign esgotou = 1'b0;
`endif

  jogo_memoria_uc u_uc (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .borda         (borda),
    .igual         (igual),
    .fim           (fim),
    .esgotou       (esgotou),
    .zera          (zera),
    .registra      (registra),
    .conta         (conta),
    .pode_carregar (pode_carregar),
    .pronto        (pronto),
    .acertou       (acertou),
    .errou         (errou),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  assign db_contagem = indice;
  assign db_memoria  = mem[indice];
  assign db_chaves   = jogada_reg;
  assign db_igual    = igual;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param (WIDTH=4, DEPTH=4, TIMEOUT_CYCLES=8, memory 1,2,4,8).
module tb_jogo_memoria_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int TOUT  = 8;
  localparam int AW    = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             iniciar;
  logic [WIDTH-1:0] chaves;
  logic             jogada;
  logic             carrega;
  logic [AW-1:0]    carga_end;
  logic [WIDTH-1:0] carga_dado;
  logic             pronto;
  logic             acertou;
  logic             errou;
  logic             timeout;
  logic [AW-1:0]    db_contagem;
  logic [WIDTH-1:0] db_memoria;
  logic [WIDTH-1:0] db_chaves;
  logic [3:0]       db_estado;
  logic             db_igual;

  int total = 0;
  int bad   = 0;

  jogo_memoria_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .chaves      (chaves),
    .jogada      (jogada),
    .carrega     (carrega),
    .carga_end   (carga_end),
    .carga_dado  (carga_dado),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .timeout     (timeout),
    .db_contagem (db_contagem),
    .db_memoria  (db_memoria),
    .db_chaves   (db_chaves),
    .db_estado   (db_estado),
    .db_igual    (db_igual)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic [3:0] st, input logic p,
                       input logic a, input logic e, input logic t);
    chk({tag, "_estado"}, 32'(db_estado), 32'(st));
    chk({tag, "_pronto"}, 32'(pronto), 32'(p));
    chk({tag, "_acertou"}, 32'(acertou), 32'(a));
    chk({tag, "_errou"}, 32'(errou), 32'(e));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    chk("start_prep", 32'(db_estado), 32'h1);
    iniciar = 1'b0;
    tick();
    chk("start_espera", 32'(db_estado), 32'h2);
  endtask

  // One play: edge, REGISTRA, COMPARA, then the result state three cycles after the edge.
  task automatic play(input logic [3:0] v, input logic [3:0] res);
    chaves = v;
    jogada = 1'b1;
    tick();
    chk("play_registra", 32'(db_estado), 32'h4);
    jogada = 1'b0;
    tick();
    chk("play_compara", 32'(db_estado), 32'h5);
    tick();
    chk("play_result", 32'(db_estado), 32'(res));
    if (res == 4'h6) tick();
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    carrega    = 1'b1;
    carga_end  = a;
    carga_dado = d;
    tick();
    carrega = 1'b0;
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; chaves = '0; jogada = 1'b0;
    carrega = 1'b0; carga_end = '0; carga_dado = '0;
    tick();
    tick();
    flags("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_cont", 32'(db_contagem), 32'h0);
    chk("reset_chaves", 32'(db_chaves), 32'h0);
    reset = 1'b1;

    load(2'd0, 4'h1); load(2'd1, 4'h2); load(2'd2, 4'h4); load(2'd3, 4'h8);
    chk("load_mem0", 32'(db_memoria), 32'h1);

    // Edge in INICIAL is ignored
    jogada = 1'b1; tick(); jogada = 1'b0; tick();
    chk("edge_inicial", 32'(db_estado), 32'h0);

    // Full correct sequence
    start();
    play(4'h1, 4'h6);
    chk("seq_cont1", 32'(db_contagem), 32'h1);
    play(4'h2, 4'h6);
    play(4'h4, 4'h6);
    chk("seq_cont3", 32'(db_contagem), 32'h3);
    play(4'h8, 4'hA);
    flags("acerto", 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("acerto_hold", 32'(db_estado), 32'hA);

    // Wrong second play
    start();
    chk("restart_cont", 32'(db_contagem), 32'h0);
    play(4'h1, 4'h6);
    play(4'h4, 4'hE);
    flags("erro", 4'hE, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("erro_cont", 32'(db_contagem), 32'h1);
    chk("erro_chaves", 32'(db_chaves), 32'h4);
    chk("erro_igual", 32'(db_igual), 32'h0);
    chk("erro_mem", 32'(db_memoria), 32'h2);

    // Write and restart in the same cycle
    carrega = 1'b1; carga_end = 2'd0; carga_dado = 4'h9; iniciar = 1'b1;
    tick();
    chk("wr_start_prep", 32'(db_estado), 32'h1);
    carrega = 1'b0; iniciar = 1'b0;
    tick();
    chk("wr_start_mem0", 32'(db_memoria), 32'h9);
    play(4'h9, 4'h6);
    play(4'h2, 4'h6);
    play(4'h4, 4'h6);
    play(4'h8, 4'hA);
    chk("wr_start_acertou", 32'(acertou), 32'h1);
    load(2'd0, 4'h1);

    // Held jogada counts once; write during ESPERA is ignored
    start();
    chaves = 4'h1;
    jogada = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    jogada = 1'b0;
    tick();
    chk("held_cont", 32'(db_contagem), 32'h1);
    chk("held_estado", 32'(db_estado), 32'h2);
    load(2'd1, 4'hF);
    chk("espera_wr_mem", 32'(db_memoria), 32'h2);
    play(4'h2, 4'h6);
    play(4'h4, 4'h6);
    play(4'h8, 4'hA);
    chk("held_acertou", 32'(acertou), 32'h1);

    // Reset mid-game retains memory
    start();
    play(4'h1, 4'h6);
    play(4'h2, 4'h6);
    chk("mid_cont2", 32'(db_contagem), 32'h2);
    reset = 1'b0;
    tick();
    flags("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_cont", 32'(db_contagem), 32'h0);
    chk("mid_reset_chaves", 32'(db_chaves), 32'h0);
    reset = 1'b1;
    start();
    play(4'h1, 4'h6);
    play(4'h2, 4'h6);
    play(4'h4, 4'h6);
    play(4'h8, 4'hA);
    flags("retained", 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);

    // Idle ESPERA
    start();
`ifdef JOGO_TIMEOUT_EN
    for (int i = 0; i < TOUT - 1; i++) tick();
    flags("pre_timeout", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    flags("timeout", 4'hD, 1'b1, 1'b0, 1'b0, 1'b1);
    start();
    for (int i = 0; i < TOUT - 1; i++) tick();
    chaves = 4'h1;
    jogada = 1'b1;
    tick();
    chk("edge_wins", 32'(db_estado), 32'h4);
    jogada = 1'b0;
    tick();
    tick();
    chk("edge_wins_next", 32'(db_estado), 32'h6);
`else
    for (int i = 0; i < 100; i++) tick();
    flags("no_timeout", 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
